// File: rtl/fsm_table_param_if.sv
// Bus between the FSM and its driver.
// The master drives the condition inputs, hold and the table write port.
// The slave drives back state, the change pulse and the dwell count.
interface fsm_table_param_if #(
    parameter int SW = 4,
    parameter int IW = 2,
    parameter int CW = 8
);
    localparam int CFGW = 1 + 2*IW + 2*SW;

    logic [IW-1:0]   input_vec;
    logic            hold;
    logic            cfg_we;
    logic [SW-1:0]   cfg_addr;
    logic [CFGW-1:0] cfg_wdata;
    logic [SW-1:0]   state;
    logic            state_changed;
    logic [CW-1:0]   dwell;

    modport master (
        output input_vec, hold, cfg_we, cfg_addr, cfg_wdata,
        input  state, state_changed, dwell
    );

    modport slave (
        input  input_vec, hold, cfg_we, cfg_addr, cfg_wdata,
        output state, state_changed, dwell
    );
endinterface

// File: rtl/fsm_table_param.sv
// Table-driven FSM.
// Each state owns a runtime-writable entry holding a branch condition and its two successors.
// Reset reloads the legacy binary-tree walk into every entry.
// A state-change pulse and a saturating dwell counter are provided for debug.
module fsm_table_param #(
    parameter int SW = 4,
    parameter int IW = 2,
    parameter int CW = 8
) (
    input logic clk,
    input logic reset,
    fsm_table_param_if.slave bus
);
    localparam int NS       = 2**SW;
    localparam int CFGW     = 1 + 2*IW + 2*SW;
    localparam int NF_LSB   = 0;
    localparam int NT_LSB   = SW;
    localparam int MASK_LSB = 2*SW;
    localparam int POL_LSB  = 2*SW + IW;
    localparam int MODE_BIT = CFGW - 1;

    // Default entry: the tree successors are 2s+1 and 2s+2.
    // Mode and polarity come from the low state bits.
    // Only input bits 0 and 1 take part in the condition.
    function automatic logic [CFGW-1:0] def_entry(input int s);
        logic [SW-1:0] nt;
        logic [SW-1:0] nf;
        logic [IW-1:0] pol;
        logic [IW-1:0] mask;
        logic          mode;
        nt        = SW'((2*s + 1) % NS);
        nf        = SW'((2*s + 2) % NS);
        pol       = '0;
        pol[0]    = 1'((s >> 0) & 1);
        pol[1]    = 1'((s >> 1) & 1);
        mask      = '0;
        mask[1:0] = 2'b11;
        mode      = 1'((s >> 2) & 1);
        return {mode, pol, mask, nt, nf};
    endfunction

    logic [NS-1:0][CFGW-1:0] tbl_q, tbl_d;
    logic [SW-1:0]           state_q, state_d;
    logic                    changed_q, changed_d;
    logic [CW-1:0]           dwell_q, dwell_d;

    logic [CFGW-1:0] cur;
    logic [IW-1:0]   t;
    logic [IW-1:0]   mask;
    logic            cond;

    // Table write port: the write lands on this edge, so the transition on the same edge still sees the old entry.
    always_comb begin
        tbl_d = tbl_q;
        if (bus.cfg_we)
            tbl_d[bus.cfg_addr] = bus.cfg_wdata;
    end

    // Table storage; reset restores defaults and drops any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++)
                tbl_q[i] <= def_entry(i);
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // State register with change pulse and dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= '0;
            changed_q <= 1'b0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
            dwell_q   <= dwell_d;
        end
    end

    // Next state: evaluate the current state's entry; hold freezes the state.
    always_comb begin
        cur     = tbl_q[state_q];
        t       = bus.input_vec ^ cur[POL_LSB +: IW];
        mask    = cur[MASK_LSB +: IW];
        cond    = cur[MODE_BIT] ? |(t & mask) : &(t | ~mask);
        state_d = state_q;
        if (!bus.hold)
            state_d = cond ? cur[NT_LSB +: SW] : cur[NF_LSB +: SW];
    end

    // Observability: pulse only on a real value change.
    // Dwell counts self-loops and hold as well.
    always_comb begin
        changed_d = (state_d != state_q);
        dwell_d   = dwell_q;
        if (changed_d)
            dwell_d = '0;
        else if (dwell_q != {CW{1'b1}})
            dwell_d = dwell_q + 1'b1;
    end

    assign bus.state         = state_q;
    assign bus.state_changed = changed_q;
    assign bus.dwell         = dwell_q;
endmodule

// File: tb/tb_fsm_table_param.sv
module tb_fsm_table_param;
    localparam int SW = 4, IW = 2, CW = 8, NS = 16, CFGW = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_table_param_if #(.SW(SW), .IW(IW), .CW(CW)) bus ();

    fsm_table_param #(.SW(SW), .IW(IW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ch;
        logic [7:0] dw;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [CFGW-1:0] m_tbl [NS];
    logic [3:0]      m_state;
    logic            m_ch;
    logic [7:0]      m_dw;

    function automatic logic [CFGW-1:0] m_default(input int s);
        logic [3:0] nt, nf;
        logic [1:0] pol;
        logic       mode;
        nt   = 4'((2*s + 1) % 16);
        nf   = 4'((2*s + 2) % 16);
        pol  = {s[1], s[0]};
        mode = s[2];
        return {mode, pol, 2'b11, nt, nf};
    endfunction

    function automatic logic m_cond(input logic [CFGW-1:0] e, input logic [1:0] iv);
        logic c;
        logic ti;
        c = e[12] ? 1'b0 : 1'b1;
        for (int i = 0; i < 2; i++) begin
            ti = iv[i] ^ e[10 + i];
            if (e[8 + i]) begin
                if (e[12] && ti) c = 1'b1;
                if (!e[12] && !ti) c = 1'b0;
            end
        end
        return c;
    endfunction

    task automatic cmp_fields(input string tag, input exp_t e);
        total++;
        assert (bus.state === e.st) else begin
            bad++; $error("FAIL %s state got=%0d exp=%0d", tag, bus.state, e.st);
        end
        total++;
        assert (bus.state_changed === e.ch) else begin
            bad++; $error("FAIL %s state_changed got=%0b exp=%0b", tag, bus.state_changed, e.ch);
        end
        total++;
        assert (bus.dwell === e.dw) else begin
            bad++; $error("FAIL %s dwell got=%0d exp=%0d", tag, bus.dwell, e.dw);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic rst, input logic [1:0] iv, input logic hd,
                        input logic we, input logic [3:0] ad, input logic [CFGW-1:0] wd,
                        input string tag);
        logic [3:0] nxt;
        exp_t e;
        reset = rst; bus.input_vec = iv; bus.hold = hd;
        bus.cfg_we = we; bus.cfg_addr = ad; bus.cfg_wdata = wd;
        if (rst) begin
            for (int s = 0; s < NS; s++) m_tbl[s] = m_default(s);
            m_state = 4'd0; m_ch = 1'b0; m_dw = 8'd0;
        end else begin
            if (hd) nxt = m_state;
            else nxt = m_cond(m_tbl[m_state], iv) ? m_tbl[m_state][7:4] : m_tbl[m_state][3:0];
            m_ch = (nxt != m_state);
            if (m_ch) m_dw = 8'd0;
            else if (m_dw != 8'hFF) m_dw = m_dw + 8'd1;
            if (we) m_tbl[ad] = wd;
            m_state = nxt;
        end
        q.push_back('{st: m_state, ch: m_ch, dw: m_dw});
        @(posedge clk);
        #1;
        total++;
        assert (q.size() > 0) else begin
            bad++; $error("FAIL %s scoreboard empty got=0 exp=1", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp_fields(tag, e);
        end
    endtask

    task automatic run(input logic [1:0] iv, input string tag);
        step(1'b0, iv, 1'b0, 1'b0, 4'd0, '0, tag);
    endtask

    // Directed check against hand-derived constants
    task automatic chk(input string tag, input logic [3:0] st, input logic ch, input logic [7:0] dw);
        exp_t e;
        e = '{st: st, ch: ch, dw: dw};
        cmp_fields({tag, "_const"}, e);
    endtask

    initial begin
        reset = 1'b1;
        bus.input_vec = '0; bus.hold = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_addr = '0; bus.cfg_wdata = '0;

        // Reset state
        step(1'b1, 2'b00, 1'b0, 1'b1, 4'd0, 13'h1FFF, "reset0");
        step(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, '0, "reset1");
        chk("reset", 4'd0, 1'b0, 8'd0);

        // 1. default walk
        run(2'b11, "walk1"); chk("walk1", 4'd1, 1'b1, 8'd0);
        run(2'b10, "walk2"); chk("walk2", 4'd3, 1'b1, 8'd0);
        run(2'b00, "walk3"); chk("walk3", 4'd7, 1'b1, 8'd0);
        run(2'b11, "walk4"); chk("walk4", 4'd0, 1'b1, 8'd0);

        // 2. self-loop at S14
        run(2'b00, "to2");
        run(2'b00, "to6");
        run(2'b10, "to14"); chk("to14", 4'd14, 1'b1, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            run(2'b10, "selfloop");
            chk("selfloop", 4'd14, 1'b0, 8'(i));
        end

        // 3. hold with saturation, then release
        for (int i = 0; i < 300; i++)
            step(1'b0, 2'(i), 1'b1, 1'b0, 4'd0, '0, "hold");
        chk("hold_sat", 4'd14, 1'b0, 8'd255);
        run(2'b00, "release"); chk("release", 4'd13, 1'b1, 8'd0);

        // 4. config write race in S0
        step(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, '0, "rst4");
        step(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, {1'b0, 2'b00, 2'b00, 4'd9, 4'd2}, "race");
        chk("race_old_entry", 4'd2, 1'b1, 8'd0);
        step(1'b0, 2'b00, 1'b1, 1'b1, 4'd2, {1'b0, 2'b00, 2'b00, 4'd0, 4'd0}, "wr_hold");
        chk("wr_hold", 4'd2, 1'b0, 8'd1);
        run(2'b11, "back0"); chk("back0", 4'd0, 1'b1, 8'd0);
        run(2'b00, "new_entry"); chk("new_entry", 4'd9, 1'b1, 8'd0);

        // 5. reset mid-walk after a custom write
        step(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, '0, "rst5");
        step(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, {1'b0, 2'b00, 2'b00, 4'd5, 4'd5}, "wr5");
        run(2'b00, "walk5");
        chk("walk5", 4'd6, 1'b1, 8'd0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, '0, "midreset");
        chk("midreset", 4'd0, 1'b0, 8'd0);
        run(2'b11, "restored"); chk("restored", 4'd1, 1'b1, 8'd0);

        // 6. random regression against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 2'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 4'($urandom),
                 13'($urandom),
                 "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
